// File: rtl/booth_mult_sched.sv
// Operand scheduler and in-order result buffer wrapped around a sequential
// radix-4 Booth multiplier with a start/done handshake.
module booth_mult_sched #(
  parameter int N       = 32,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*N-1:0]           out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     mul_start,
  output logic [N-1:0]             mul_multiplier,
  input  logic                     mul_done,
  input  logic [2*N-1:0]           mul_product,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic                     err_timeout,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int EW = N + TAG_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [EW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]     count_r;
  logic [TAG_W-1:0]  tag_cnt_r;
  logic [N-1:0]      cur_data_r;
  logic [TAG_W-1:0]  cur_tag_r;
  logic              done_q_r;
  logic [CW-1:0]     tmo_cnt_r;
  logic              out_valid_r;
  logic [2*N-1:0]    out_data_r;
  logic [TAG_W-1:0]  out_tag_r;
  logic              err_r;

  logic full_s, empty_s, push_s, pop_s, event_s, out_free_s, tmo_hit_s;
  logic load_s, fetch_s, tmo_set_s;

  assign full_s     = (count_r == LW'(DEPTH));
  assign empty_s    = (count_r == LW'(1'b0));
  assign push_s     = in_valid && !full_s;
  assign pop_s      = (state_r == S_ISSUE);
  assign event_s    = mul_done && !done_q_r;
  assign out_free_s = !out_valid_r || out_ready;
  // The counter holds elapsed WAIT cycles minus one, so this fires on the TIMEOUT-th cycle after start.
  assign tmo_hit_s  = (tmo_cnt_r == CW'(TIMEOUT - 1));

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    fetch_s   = 1'b0;
    tmo_set_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!empty_s) begin
          fetch_s = 1'b1;
          state_s = S_ISSUE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: state_s = S_WAIT;
      S_WAIT: begin
        if (event_s) begin
          if (out_free_s) begin
            load_s  = 1'b1;
            state_s = S_IDLE;
          end else begin
            state_s = S_HOLD;
          end
        end else if (tmo_hit_s) begin
          tmo_set_s = 1'b1;
          state_s   = S_IDLE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (out_free_s) begin
          load_s  = 1'b1;
          state_s = S_IDLE;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register and done edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      done_q_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      done_q_r <= mul_done;
    end
  end

  // Input FIFO storage, pointers, occupancy and tag assignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      tag_cnt_r <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {in_data, tag_cnt_r};
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
        tag_cnt_r       <= tag_cnt_r + TAG_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LW'(1'b1);
        2'b01:   count_r <= count_r - LW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head is latched on entry to ISSUE so the operand is already valid alongside the start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_data_r <= '0;
      cur_tag_r  <= '0;
      tmo_cnt_r  <= '0;
    end else begin
      if (fetch_s) begin
        {cur_data_r, cur_tag_r} <= mem_r[rd_ptr_r];
      end
      if (state_r == S_ISSUE) begin
        tmo_cnt_r <= '0;
      end else if (state_r == S_WAIT) begin
        tmo_cnt_r <= tmo_cnt_r + CW'(1'b1);
      end
    end
  end

  // Output holding register; a same-cycle drain and load keeps it valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_tag_r   <= '0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= mul_product;
      out_tag_r   <= cur_tag_r;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (tmo_set_s) begin
      err_r <= 1'b1;
    end else if (clr_err) begin
      err_r <= 1'b0;
    end
  end

  assign in_ready       = !full_s;
  assign out_valid      = out_valid_r;
  assign out_data       = out_data_r;
  assign out_tag        = out_tag_r;
  assign mul_start      = (state_r == S_ISSUE);
  assign mul_multiplier = cur_data_r;
  assign fifo_level     = count_r;
  assign busy           = (state_r != S_IDLE) || !empty_s;
  assign err_timeout    = err_r;

endmodule

// File: tb/tb_booth_mult_sched.sv
// Directed bench for booth_mult_sched with a behavioural multiplier model
// (multiplicand 0x5555_5555, signed) that can be switched to a never-done stub.
module tb_booth_mult_sched;

  localparam int N = 32, DEPTH = 4, TAG_W = 4, TIMEOUT = 63, LAT = 17;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, mul_start, mul_done;
  logic busy, err_timeout, clr_err;
  logic [31:0] in_data, mul_multiplier, m_op;
  logic [63:0] out_data, mul_product;
  logic [3:0] out_tag;
  logic [2:0] fifo_level;
  bit never_done = 1'b0;
  int m_cnt;

  int checks = 0, failures = 0, cyc = 0;
  logic [67:0] res_q[$];
  int start_q[$];
  int err_q[$];
  int ov_n = 0, fb_n = 0, fa_n = 0;
  logic err_prev = 1'b0;

  booth_mult_sched #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .mul_start(mul_start), .mul_multiplier(mul_multiplier), .mul_done(mul_done),
    .mul_product(mul_product), .fifo_level(fifo_level), .busy(busy),
    .err_timeout(err_timeout), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] booth_ref(input logic [31:0] b);
    logic signed [63:0] a;
    a = {{32{b[31]}}, b};
    return a * 64'sh0000_0000_5555_5555;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_done <= 1'b0; mul_product <= '0; m_op <= '0; m_cnt <= 0;
    end else if (mul_start) begin
      mul_done <= 1'b0; m_op <= mul_multiplier; m_cnt <= LAT;
    end else if (m_cnt == 1) begin
      m_cnt <= 0;
      if (!never_done) begin
        mul_done <= 1'b1; mul_product <= booth_ref(m_op);
      end
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    err_prev <= err_timeout;
    if (rst_n) begin
      if (out_valid && out_ready) res_q.push_back({out_data, out_tag});
      if (out_valid) ov_n <= ov_n + 1;
      if (mul_start) start_q.push_back(cyc);
      if (err_timeout && !err_prev) err_q.push_back(cyc);
      if (fifo_level == 3'd4 && !in_ready) fb_n <= fb_n + 1;
      if (fifo_level == 3'd4 && in_ready) fa_n <= fa_n + 1;
    end
  end

  task automatic do_reset();
    in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1; clr_err = 1'b0; never_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    res_q.delete(); start_q.delete(); err_q.delete();
  endtask

  task automatic push(input logic [31:0] d, output int acc_cyc, output bit ok);
    int waited;
    waited = 0; ok = 1'b0; acc_cyc = -1;
    in_valid = 1'b1; in_data = d;
    while (!ok && waited < 300) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; acc_cyc = cyc; end
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0; clr_err = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 64'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_tag !== 4'd0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    checks++; if (mul_start !== 1'b0) begin failures++; $display("FAIL reset_mul_start got=%b exp=0", mul_start); end
    checks++; if (mul_multiplier !== 32'd0) begin failures++; $display("FAIL reset_mul_multiplier got=%h exp=0", mul_multiplier); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_fifo_level got=%0d exp=0", fifo_level); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err_timeout got=%b exp=0", err_timeout); end
  endtask

  task automatic test_single();
    int t; bit ok; logic [67:0] r;
    do_reset();
    push(32'd3, t, ok);
    for (int i = 0; i < 100 && res_q.size() < 1; i++) @(posedge clk);
    repeat (30) @(posedge clk);
    #1;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_push got=%b exp=1", ok); end
    checks++; if (res_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", res_q.size()); end
    if (res_q.size() >= 1) begin
      r = res_q[0];
      checks++; if (r[67:4] !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL single_data got=%h exp=00000000ffffffff", r[67:4]); end
      checks++; if (r[3:0] !== 4'd0) begin failures++; $display("FAIL single_tag got=%0d exp=0", r[3:0]); end
    end
    checks++; if (start_q.size() != 1) begin failures++; $display("FAIL single_start_cycles got=%0d exp=1", start_q.size()); end
    if (start_q.size() >= 1) begin
      checks++; if (start_q[0] != t + 2) begin failures++; $display("FAIL single_issue_latency got=%0d exp=%0d", start_q[0], t + 2); end
    end
  endtask

  task automatic test_signed();
    logic [31:0] ops [3];
    logic [63:0] exp_d [3];
    int t; bit ok; logic [67:0] r;
    ops[0] = 32'h0000_0000; exp_d[0] = 64'h0000_0000_0000_0000;
    ops[1] = 32'hFFFF_FFFF; exp_d[1] = 64'hFFFF_FFFF_AAAA_AAAB;
    ops[2] = 32'h0000_0002; exp_d[2] = 64'h0000_0000_AAAA_AAAA;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push(ops[k], t, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL signed_push%0d got=%b exp=1", k, ok); end
    end
    for (int i = 0; i < 200 && res_q.size() < 3; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (res_q.size() != 3) begin failures++; $display("FAIL signed_count got=%0d exp=3", res_q.size()); end
    for (int k = 0; k < 3 && k < res_q.size(); k++) begin
      r = res_q[k];
      checks++; if (r[67:4] !== exp_d[k]) begin failures++; $display("FAIL signed_data%0d got=%h exp=%h", k, r[67:4], exp_d[k]); end
      checks++; if (r[3:0] !== 4'(k)) begin failures++; $display("FAIL signed_tag%0d got=%0d exp=%0d", k, r[3:0], k); end
    end
  endtask

  task automatic test_backpressure();
    int t, fb0, fa0; bit ok; logic [67:0] r; logic [63:0] e;
    do_reset();
    out_ready = 1'b0;
    fb0 = fb_n; fa0 = fa_n;
    for (int k = 1; k <= 6; k++) begin
      push(32'(k), t, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_push%0d got=%b exp=1", k, ok); end
    end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL bp_level got=%0d exp=4", fifo_level); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 64'h0000_0000_5555_5555) begin failures++; $display("FAIL bp_out_data got=%h exp=0000000055555555", out_data); end
    checks++; if (start_q.size() != 2) begin failures++; $display("FAIL bp_starts_held got=%0d exp=2", start_q.size()); end
    checks++; if (fb_n <= fb0) begin failures++; $display("FAIL bp_full_block got=%0d exp>%0d", fb_n, fb0); end
    checks++; if (fa_n != fa0) begin failures++; $display("FAIL bp_full_accept got=%0d exp=%0d", fa_n, fa0); end
    out_ready = 1'b1;
    for (int i = 0; i < 400 && res_q.size() < 6; i++) @(posedge clk);
    repeat (30) @(posedge clk);
    #1;
    checks++; if (res_q.size() != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", res_q.size()); end
    for (int k = 0; k < 6 && k < res_q.size(); k++) begin
      r = res_q[k];
      e = 64'(k + 1) * 64'h5555_5555;
      checks++; if (r[67:4] !== e) begin failures++; $display("FAIL bp_data%0d got=%h exp=%h", k, r[67:4], e); end
      checks++; if (r[3:0] !== 4'(k)) begin failures++; $display("FAIL bp_tag%0d got=%0d exp=%0d", k, r[3:0], k); end
    end
  endtask

  task automatic test_tag_wrap();
    int t; bit ok; logic [67:0] r; logic [63:0] e; logic [31:0] op;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      push(32'(k) * 32'd4099 + 32'd11, t, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wrap_push%0d got=%b exp=1", k, ok); end
    end
    for (int i = 0; i < 300 && res_q.size() < 20; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (res_q.size() != 20) begin failures++; $display("FAIL wrap_count got=%0d exp=20", res_q.size()); end
    for (int k = 0; k < 20 && k < res_q.size(); k++) begin
      r = res_q[k];
      op = 32'(k) * 32'd4099 + 32'd11;
      e = 64'(op) * 64'h5555_5555;
      checks++; if (r[67:4] !== e) begin failures++; $display("FAIL wrap_data%0d got=%h exp=%h", k, r[67:4], e); end
      checks++; if (r[3:0] !== 4'(k % 16)) begin failures++; $display("FAIL wrap_tag%0d got=%0d exp=%0d", k, r[3:0], k % 16); end
    end
  endtask

  task automatic test_timeout();
    int t, s, ov0, s2; bit ok;
    do_reset();
    never_done = 1'b1;
    ov0 = ov_n;
    push(32'd7, t, ok);
    push(32'd9, t, ok);
    for (int i = 0; i < 20 && start_q.size() < 1; i++) @(posedge clk);
    #1;
    checks++; if (start_q.size() < 1) begin failures++; $display("FAIL tmo_first_start got=%0d exp=1", start_q.size()); end
    if (start_q.size() >= 1) begin
      s = start_q[0];
      s2 = s + TIMEOUT + 2;
      while (cyc < s + TIMEOUT + 4) begin @(posedge clk); #1; end
      checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_err_set got=%b exp=1", err_timeout); end
      checks++; if (err_q.size() < 1 || err_q[0] != s + TIMEOUT + 1) begin failures++; $display("FAIL tmo_err_cycle got=%0d exp=%0d", (err_q.size() > 0) ? err_q[0] : -1, s + TIMEOUT + 1); end
      checks++; if (start_q.size() != 2 || start_q[1] != s2) begin failures++; $display("FAIL tmo_next_issue got=%0d exp=%0d", (start_q.size() > 1) ? start_q[1] : -1, s2); end
      while (cyc < s2 + TIMEOUT) begin @(posedge clk); #1; end
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_clr_vs_set got=%b exp=1", err_timeout); end
      repeat (3) @(posedge clk);
      #1 clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_clr got=%b exp=0", err_timeout); end
      checks++; if (ov_n != ov0) begin failures++; $display("FAIL tmo_no_out_valid got=%0d exp=%0d", ov_n - ov0, 0); end
    end
    never_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t; bit ok;
    do_reset();
    push(32'd5, t, ok);
    push(32'd6, t, ok);
    push(32'd8, t, ok);
    for (int i = 0; i < 20 && start_q.size() < 1; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL mid_level_before got=%0d exp=2", fifo_level); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (mul_start !== 1'b0) begin failures++; $display("FAIL mid_mul_start got=%b exp=0", mul_start); end
    checks++; if (mul_multiplier !== 32'd0) begin failures++; $display("FAIL mid_mul_multiplier got=%h exp=0", mul_multiplier); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL mid_level got=%0d exp=0", fifo_level); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    res_q.delete(); start_q.delete();
    repeat (80) @(posedge clk);
    #1;
    checks++; if (res_q.size() != 0) begin failures++; $display("FAIL mid_no_result got=%0d exp=0", res_q.size()); end
    checks++; if (start_q.size() != 0) begin failures++; $display("FAIL mid_no_start got=%0d exp=0", start_q.size()); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL mid_level_after got=%0d exp=0", fifo_level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_backpressure();
    test_tag_wrap();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
